// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO write port; grant one cycle after request,
// then zero-latency byte pass-through; tx_full stalls the owner (req_ready low) without losing or duplicating bytes.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int IDLE_TIMEOUT = 255,
    parameter int PTR_BITS     = $clog2(NUM_REQ)
) (
    input  logic                          UCLK,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         W_data,
    output logic                          wr_uart,
    input  logic                          tx_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;
    localparam int         CNT_W   = 16;

    logic [0:0]          state_q,    state_d;
    logic [PTR_BITS-1:0] owner_q,    owner_d;
    logic [NUM_REQ-1:0]  grant_q,    grant_d;
    logic [PTR_BITS-1:0] rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                timeout_q,  timeout_d;

    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  found;
    logic [PTR_BITS-1:0]   pick;
    logic [PTR_BITS-1:0]   ptr_next;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  in_send;

    // Owner's signals, muxed from the registered owner index.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == PTR_BITS'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                found = 1'b1;
                pick  = PTR_BITS'(idx);
            end
        end
    end

    assign in_send   = (state_q == ST_SEND);
    assign ptr_next  = (owner_q == PTR_BITS'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign cnt_inc   = idle_cnt_q + 1'b1;

    assign busy        = in_send;
    assign grant       = grant_q;
    assign timeout_err = timeout_q;
    assign wr_uart     = in_send & sel_valid & ~tx_full;
    assign req_ready   = (in_send && !tx_full) ? grant_q : '0;
    assign W_data      = wr_uart ? sel_data : '0;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (found) begin
                state_d    = ST_SEND;
                owner_d    = pick;
                grant_d    = NUM_REQ'(1) << pick;
                idle_cnt_d = '0;
            end
        end else begin
            if (sel_valid) begin
                // A valid owner held off by tx_full is not idle.
                idle_cnt_d = '0;
                if (!tx_full && sel_last) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = ptr_next;
                end
            end else if (cnt_inc == CNT_W'(IDLE_TIMEOUT)) begin
                timeout_d  = 1'b1;
                state_d    = ST_IDLE;
                grant_d    = '0;
                rr_ptr_d   = ptr_next;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge UCLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: 4 clients, byte width 8, watchdog timeout of 4 cycles.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic            UCLK = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [DW-1:0]   W_data;
    logic            wr_uart;
    logic            tx_full;
    logic [NR-1:0]   grant;
    logic            busy;
    logic            timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] bp_bytes [3] = '{8'hC0, 8'hC1, 8'hC2};
    int         rr_owner [6] = '{0, 2, 3, 0, 2, 3};

    always #5 UCLK = ~UCLK;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .IDLE_TIMEOUT(4)
    ) dut (
        .UCLK(UCLK), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .W_data(W_data), .wr_uart(wr_uart),
        .tx_full(tx_full), .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge UCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_full   = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int cnt [NR];
        int pk, gap, ptr, rcv, o;
        logic [NR-1:0] prev_g, acc;

        // Reset state
        do_reset();
        settle();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr", wr_uart, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wdata", W_data, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_ptr", dut.rr_ptr_q, 0);

        // Single client 1, three-byte packet
        req_valid = 4'b0010; set_byte(1, 8'hA1);
        settle();
        chk("s1_arb_grant", grant, 0);
        chk("s1_arb_wr", wr_uart, 0);
        cyc(); settle();
        chk("s1_grant", grant, 4'b0010);
        chk("s1_b0", W_data, 8'hA1);
        chk("s1_ready", req_ready, 4'b0010);
        cyc(); set_byte(1, 8'hA2); settle();
        chk("s1_b1", W_data, 8'hA2);
        chk("s1_wr1", wr_uart, 1);
        cyc(); set_byte(1, 8'hA3); req_last = 4'b0010; settle();
        chk("s1_b2", W_data, 8'hA3);
        cyc(); req_valid = '0; req_last = '0; settle();
        chk("s1_end_grant", grant, 0);
        chk("s1_end_busy", busy, 0);
        chk("s1_ptr", dut.rr_ptr_q, 2);

        // Round robin among clients 0, 2, 3 with continuous 2-byte packets
        do_reset();
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        pk = 0; gap = 0; prev_g = '0;
        for (int c = 0; c < 18; c++) begin
            req_valid = 4'b1101;
            for (int i = 0; i < NR; i++) begin
                set_byte(i, {4'(i), 4'(cnt[i])});
                req_last[i] = (cnt[i] % 2) == 1;
            end
            settle();
            if (grant != '0 && prev_g == '0) begin
                if (pk < 6) chk("rr_grant", grant, 32'(1) << rr_owner[pk]);
                if (pk > 0) chk("rr_gap", gap, 1);
                pk++;
                gap = 0;
            end
            if (grant == '0) gap++;
            if (wr_uart) begin
                o = 0;
                for (int i = 0; i < NR; i++) if (grant[i]) o = i;
                chk("rr_data", W_data, {4'(o), 4'(cnt[o])});
            end
            acc = req_valid & req_ready;
            prev_g = grant;
            cyc();
            for (int i = 0; i < NR; i++) if (acc[i]) cnt[i]++;
        end
        chk("rr_pkts", pk, 6);

        // Backpressure: tx_full for 5 cycles while the last byte is offered
        do_reset();
        ptr = 0; rcv = 0;
        for (int c = 0; c < 12; c++) begin
            tx_full = (c >= 3 && c <= 7);
            if (ptr < 3) begin
                req_valid = 4'b0100;
                set_byte(2, bp_bytes[ptr]);
                req_last = (ptr == 2) ? 4'b0100 : 4'b0000;
            end else begin
                req_valid = '0;
                req_last  = '0;
            end
            settle();
            chk("bp_tmo", timeout_err, 0);
            if (tx_full) begin
                chk("bp_wr", wr_uart, 0);
                chk("bp_ready", req_ready, 0);
                chk("bp_wdata", W_data, 0);
                chk("bp_grant", grant, 4'b0100);
            end
            if (wr_uart) begin
                chk("bp_data", W_data, bp_bytes[ptr < 3 ? ptr : 2]);
                rcv++;
            end
            acc = req_valid & req_ready;
            cyc();
            if (acc[2]) ptr++;
        end
        tx_full = 1'b0;
        chk("bp_rcv", rcv, 3);
        chk("bp_ptr", ptr, 3);
        chk("bp_end_grant", grant, 0);

        // Watchdog: owner 0 stalls after one byte, client 1 waiting
        do_reset();
        req_valid = 4'b0011; set_byte(0, 8'hD0); set_byte(1, 8'hD1);
        settle();
        chk("wd_arb_grant", grant, 0);
        cyc(); settle();
        chk("wd_grant0", grant, 4'b0001);
        chk("wd_b0", W_data, 8'hD0);
        cyc();
        req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("wd_idle_tmo", timeout_err, 0);
            chk("wd_idle_grant", grant, 4'b0001);
            chk("wd_idle_wr", wr_uart, 0);
            chk("wd_idle_ready", req_ready, 4'b0001);
            cyc();
        end
        settle();
        chk("wd_pulse", timeout_err, 1);
        chk("wd_rev_grant", grant, 0);
        chk("wd_rev_busy", busy, 0);
        cyc(); settle();
        chk("wd_next_grant", grant, 4'b0010);
        chk("wd_pulse_end", timeout_err, 0);

        // Reset during byte 2 of 4 from client 3
        do_reset();
        req_valid = 4'b1000; set_byte(3, 8'hE0);
        settle();
        cyc(); settle();
        chk("mr_grant", grant, 4'b1000);
        chk("mr_b0", W_data, 8'hE0);
        cyc(); set_byte(3, 8'hE1); reset = 1'b1; settle();
        chk("mr_b1_wr", wr_uart, 1);
        cyc(); reset = 1'b0; req_valid = 4'b1001; set_byte(0, 8'h70); settle();
        chk("mr_grant0", grant, 0);
        chk("mr_wr0", wr_uart, 0);
        chk("mr_busy0", busy, 0);
        chk("mr_ptr0", dut.rr_ptr_q, 0);
        cyc(); settle();
        chk("mr_win", grant, 4'b0001);

        // Owner 3 last byte while 0 and 3 request: pointer wraps to 0
        do_reset();
        req_valid = 4'b1000; set_byte(3, 8'hF0); req_last = 4'b1000;
        settle();
        cyc(); req_valid = 4'b1001; settle();
        chk("wr_grant3", grant, 4'b1000);
        chk("wr_last_wr", wr_uart, 1);
        chk("wr_last_data", W_data, 8'hF0);
        cyc(); settle();
        chk("wr_idle", grant, 0);
        chk("wr_ptr", dut.rr_ptr_q, 0);
        cyc(); settle();
        chk("wr_next", grant, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
